// File: rtl/dm_access_master.sv
// dm_access_master: single-outstanding load/store initiator for the data
// memory. Handles sub-word extension on loads and read-modify-write for
// sb/sh. Misaligned or out-of-range requests complete with err and never
// touch memory.

// Per-byte-lane store merge: take the store byte when the lane is written,
// otherwise keep the byte read back from memory.
module dm_byte_lane #(
  parameter int VEC_W = 8
) (
  input  logic             en_i,
  input  logic [VEC_W-1:0] base_i,
  input  logic [VEC_W-1:0] st_i,
  output logic [VEC_W-1:0] out_o
);
  assign out_o = en_i ? st_i : base_i;
endmodule

module dm_access_master #(
  parameter logic [31:0] DM_BASE  = 32'h0000_0000,
  parameter int unsigned DM_BYTES = 4096
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        req_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] pc_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  output logic        dm_we_o,
  output logic        dm_re_o,
  output logic [31:0] dm_pc_o,
  input  logic [31:0] dm_rdata_i
);

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LD   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // 33-bit compare so DM_BASE + DM_BYTES cannot wrap at the top of memory
  localparam logic [32:0] LIM = {1'b0, DM_BASE} + 33'(DM_BYTES);

  logic [2:0]  state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q, pc_q, rdata_q, merge_q;
  logic        err_q;

  logic        misal_w, oor_w, reject_w;
  logic [31:0] ld_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  logic [NUM_LANES-1:0]            lane_en;
  logic [NUM_LANES-1:0][VEC_W-1:0] st_lanes, base_lanes, out_lanes;

  // Request qualification on the live inputs, used only at accept time
  always_comb begin
    misal_w = 1'b0;
    case (op_i)
      OP_LW, OP_SW:         misal_w = |addr_i[1:0];
      OP_LH, OP_LHU, OP_SH: misal_w = addr_i[0];
      default:              misal_w = 1'b0;
    endcase
    oor_w    = ({1'b0, addr_i} < {1'b0, DM_BASE}) || ({1'b0, addr_i} >= LIM);
    reject_w = misal_w | oor_w;
  end

  // Next-state logic; requests outside IDLE are simply not looked at
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_i) begin
        if (reject_w)          state_d = S_DONE;
        else if (op_i < OP_SW) state_d = S_LD;
        else if (op_i == OP_SW) state_d = S_WR;
        else                   state_d = S_RD;
      end
      S_LD:    state_d = S_DONE;
      S_RD:    state_d = S_WR;
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Request latch: captured once per accept, stable until the next accept
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else if (state_q == S_IDLE && req_i) begin
      op_q    <= op_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      pc_q    <= pc_i;
      err_q   <= reject_w;
    end
  end

  // Load lane select and sign/zero extension (little-endian)
  always_comb begin
    ld_byte = dm_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];
    case (op_q)
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'h0000, ld_half};
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'h000000, ld_byte};
      default: ld_ext = dm_rdata_i;
    endcase
  end

  // Load result and RMW read-back registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      if (state_q == S_LD) rdata_q <= ld_ext;
      if (state_q == S_RD) merge_q <= dm_rdata_i;
    end
  end

  // Store lane enables and replicated store data; sw writes every lane
  always_comb begin
    lane_en  = '1;
    st_lanes = wdata_q;
    case (op_q)
      OP_SB: begin
        lane_en             = '0;
        lane_en[addr_q[1:0]] = 1'b1;
        st_lanes            = {4{wdata_q[7:0]}};
      end
      OP_SH: begin
        lane_en  = addr_q[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_en  = '1;
        st_lanes = wdata_q;
      end
    endcase
    base_lanes = merge_q;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dm_byte_lane #(.VEC_W(VEC_W)) u_lane (
      .en_i   (lane_en[g]),
      .base_i (base_lanes[g]),
      .st_i   (st_lanes[g]),
      .out_o  (out_lanes[g])
    );
  end

  // Outputs decode from registered state only
  assign ready_o    = (state_q == S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign err_o      = (state_q == S_DONE) & err_q;
  assign dm_re_o    = (state_q == S_LD) | (state_q == S_RD);
  assign dm_we_o    = (state_q == S_WR);
  assign dm_wdata_o = (state_q == S_WR) ? out_lanes : '0;
  assign dm_addr_o  = {addr_q[31:2], 2'b00};
  assign dm_pc_o    = pc_q;
  assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_dm_access_master.sv
// Bench for dm_access_master: a word memory stands in for dm, and a
// byte-arithmetic reference model predicts results, latency and memory.
module tb_dm_access_master;
  localparam logic [31:0] DMB = 32'd4096;

  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] addr = '0, wdata = '0, pc = '0;
  logic        ready, done, err, dm_we, dm_re;
  logic [31:0] rdata, dm_addr, dm_wdata, dm_pc, dm_rdata;

  int checks = 0, errors = 0;
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] rdata_exp = '0;

  dm_access_master #(.DM_BASE(32'h0), .DM_BYTES(4096)) dut (
    .clk_i(clk), .reset_ni(rst_n), .req_i(req), .op_i(op), .addr_i(addr),
    .wdata_i(wdata), .pc_i(pc), .ready_o(ready), .done_o(done),
    .rdata_o(rdata), .err_o(err), .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata),
    .dm_we_o(dm_we), .dm_re_o(dm_re), .dm_pc_o(dm_pc), .dm_rdata_i(dm_rdata)
  );

  always #5 clk = ~clk;

  // dm stand-in: combinational read, write on the edge ending WR
  assign dm_rdata = mem[dm_addr[11:2]];
  always @(posedge clk) if (dm_we) mem[dm_addr[11:2]] <= dm_wdata;

  // One access through the DUT, predicted by the reference model
  task automatic access(input string nm, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] p);
    logic bad, got, e;
    logic [31:0] w, sel;
    int sh, lat, exp_lat, nwe, nre, exp_we, exp_re, abad;
    bad = (a >= DMB);
    if ((o == 0 || o == 5) && (a % 4 != 0)) bad = 1'b1;
    if ((o == 1 || o == 2 || o == 6) && (a % 2 != 0)) bad = 1'b1;
    exp_lat = bad ? 1 : (o >= 6) ? 3 : 2;
    exp_we  = (!bad && o >= 5) ? 1 : 0;
    exp_re  = (!bad && o != 5) ? 1 : 0;
    if (!bad) begin
      w  = ref_mem[a / 4];
      sh = int'(a % 4) * 8;
      case (o)
        0: rdata_exp = w;
        1: begin sel = (w >> sh) & 32'hFFFF; if (sel >= 32'h8000) sel = sel | 32'hFFFF0000; rdata_exp = sel; end
        2: rdata_exp = (w >> sh) & 32'hFFFF;
        3: begin sel = (w >> sh) & 32'hFF; if (sel >= 32'h80) sel = sel | 32'hFFFFFF00; rdata_exp = sel; end
        4: rdata_exp = (w >> sh) & 32'hFF;
        5: ref_mem[a / 4] = wd;
        6: ref_mem[a / 4] = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        default: ref_mem[a / 4] = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      endcase
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL %s ready got %b want 1", nm, ready); end
    op = o; addr = a; wdata = wd; pc = p; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; op = 3'($urandom); addr = $urandom; wdata = $urandom; pc = $urandom;
    lat = 0; nwe = 0; nre = 0; got = 1'b0; e = 1'b0; abad = 0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (dm_we === 1'b1) nwe++;
      if (dm_re === 1'b1) nre++;
      if (!bad && (dm_addr !== {a[31:2], 2'b00} || dm_pc !== p)) abad++;
      if (done === 1'b1) begin
        got = 1'b1; e = err;
        checks++;
        if (rdata !== rdata_exp) begin errors++; $display("FAIL %s rdata got %h want %h", nm, rdata, rdata_exp); end
      end
    end
    checks++;
    if (lat != exp_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", nm, lat, exp_lat); end
    checks++;
    if (e !== bad) begin errors++; $display("FAIL %s err got %b want %b", nm, e, bad); end
    checks++;
    if (nwe != exp_we || nre != exp_re) begin
      errors++; $display("FAIL %s we/re cycles got %0d/%0d want %0d/%0d", nm, nwe, nre, exp_we, exp_re);
    end
    checks++;
    if (abad != 0) begin errors++; $display("FAIL %s dm_addr/dm_pc unstable or wrong in %0d cycles want %h/%h", nm, abad, {a[31:2], 2'b00}, p); end
  endtask

  task automatic check_mem(input string nm);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL %s mem[%0d] got %h want %h", nm, i, mem[i], ref_mem[i]); end
    end
  endtask

  task automatic check_reset_outs(input string nm);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || dm_we !== 1'b0 || dm_re !== 1'b0) begin
      errors++; $display("FAIL %s ctl got rdy%b dn%b er%b we%b re%b want 1/0/0/0/0", nm, ready, done, err, dm_we, dm_re);
    end
    checks++;
    if (rdata !== 32'h0 || dm_addr !== 32'h0 || dm_wdata !== 32'h0 || dm_pc !== 32'h0) begin
      errors++; $display("FAIL %s data got %h %h %h %h want zeros", nm, rdata, dm_addr, dm_wdata, dm_pc);
    end
  endtask

  task automatic test_reset();
    #12 check_reset_outs("reset");
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_init();
    for (int i = 0; i < 16; i++) access("init", 3'd5, 32'(i * 4), $urandom, $urandom);
    check_mem("init");
  endtask

  task automatic test_sw_lw();
    access("sw0", 3'd5, 32'h0, 32'hDEADBEEF, 32'h0040_0100);
    access("lw0", 3'd0, 32'h0, 32'h0, 32'h0040_0104);
    checks++;
    if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw0 value got %h want deadbeef", rdata); end
  endtask

  task automatic test_ext();
    access("sw4", 3'd5, 32'h4, 32'h8077F0FF, 32'h100);
    access("lb4", 3'd3, 32'h4, 32'h0, 32'h104);
    checks++; if (rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb4 got %h want ffffffff", rdata); end
    access("lbu5", 3'd4, 32'h5, 32'h0, 32'h108);
    checks++; if (rdata !== 32'h000000F0) begin errors++; $display("FAIL lbu5 got %h want 000000f0", rdata); end
    access("lh6", 3'd1, 32'h6, 32'h0, 32'h10C);
    checks++; if (rdata !== 32'hFFFF8077) begin errors++; $display("FAIL lh6 got %h want ffff8077", rdata); end
    access("lhu6", 3'd2, 32'h6, 32'h0, 32'h110);
    checks++; if (rdata !== 32'h00008077) begin errors++; $display("FAIL lhu6 got %h want 00008077", rdata); end
  endtask

  task automatic test_rmw();
    access("sw8", 3'd5, 32'h8, 32'h11223344, 32'h200);
    access("sb9", 3'd7, 32'h9, 32'hFFFFFFAA, 32'h204);
    checks++; if (mem[2] !== 32'h1122AA44) begin errors++; $display("FAIL sb9 word got %h want 1122aa44", mem[2]); end
    access("shA", 3'd6, 32'hA, 32'hFFFF5566, 32'h208);
    checks++; if (mem[2] !== 32'h5566AA44) begin errors++; $display("FAIL shA word got %h want 5566aa44", mem[2]); end
  endtask

  task automatic test_errors();
    access("lw2", 3'd0, 32'h2, 32'h0, 32'h300);
    access("sh3", 3'd6, 32'h3, 32'h1234, 32'h304);
    access("sw1000", 3'd5, 32'h1000, 32'hCAFEF00D, 32'h308);
    access("lbtop", 3'd3, 32'hFFFF_FFFF, 32'h0, 32'h30C);
    check_mem("errors");
  endtask

  task automatic test_reset_mid_rmw();
    int nwe;
    access("sw10", 3'd5, 32'h10, 32'h11223344, 32'h400);
    @(negedge clk);
    op = 3'd7; addr = 32'h11; wdata = 32'hAA; pc = 32'h404; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    checks++;
    if (dm_re !== 1'b1 || dm_we !== 1'b0) begin errors++; $display("FAIL rmwrst in RD got re%b we%b want 1/0", dm_re, dm_we); end
    rst_n = 1'b0;
    #1 check_reset_outs("rmwrst");
    nwe = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (dm_we !== 1'b0) nwe++; end
    checks++;
    if (nwe != 0) begin errors++; $display("FAIL rmwrst dm_we got %0d cycles want 0", nwe); end
    rst_n = 1'b1;
    rdata_exp = '0;
    access("lw10", 3'd0, 32'h10, 32'h0, 32'h408);
    checks++;
    if (rdata !== 32'h11223344) begin errors++; $display("FAIL lw10 got %h want 11223344", rdata); end
  endtask

  // req held high; while busy, present junk that would error if accepted
  task automatic test_back_to_back();
    int nd, nre, nwe, ner;
    @(negedge clk);
    op = 3'd0; addr = 32'h0; pc = 32'h500; req = 1'b1;
    nd = 0; nre = 0; nwe = 0; ner = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) nd++;
      if (dm_re === 1'b1) nre++;
      if (dm_we === 1'b1) nwe++;
      if (err === 1'b1) ner++;
      if (ready === 1'b1) begin op = 3'd0; addr = 32'h0; end
      else begin op = 3'd0; addr = 32'h3; end
    end
    req = 1'b0;
    rdata_exp = ref_mem[0];
    checks++;
    if (nd != 10 || nre != 10 || nwe != 0 || ner != 0) begin
      errors++; $display("FAIL b2b_lw done/re/we/err got %0d/%0d/%0d/%0d want 10/10/0/0", nd, nre, nwe, ner);
    end
    checks++;
    if (rdata !== rdata_exp) begin errors++; $display("FAIL b2b_lw rdata got %h want %h", rdata, rdata_exp); end
    @(negedge clk);
    op = 3'd7; addr = 32'h9; wdata = 32'h5A; req = 1'b1;
    nd = 0; nre = 0; nwe = 0; ner = 0;
    for (int i = 0; i < 28; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) nd++;
      if (dm_re === 1'b1) nre++;
      if (dm_we === 1'b1) nwe++;
      if (err === 1'b1) ner++;
      if (ready === 1'b1) begin op = 3'd7; addr = 32'h9; wdata = 32'h5A; end
      else begin op = 3'd7; addr = 32'h1000; wdata = $urandom; end
    end
    req = 1'b0;
    ref_mem[2] = (ref_mem[2] & 32'hFFFF00FF) | 32'h00005A00;
    checks++;
    if (nd != 7 || nre != 7 || nwe != 7 || ner != 0) begin
      errors++; $display("FAIL b2b_sb done/re/we/err got %0d/%0d/%0d/%0d want 7/7/7/0", nd, nre, nwe, ner);
    end
    check_mem("b2b_sb");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       a = DMB + 32'($urandom_range(0, 255));
        1:       a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
        default: a = 32'($urandom_range(0, 63));
      endcase
      access("rand", 3'($urandom), a, $urandom, $urandom);
    end
    check_mem("rand");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    test_reset();
    test_init();
    test_sw_lw();
    test_ext();
    test_rmw();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_access_master.md
# dm_access_master

Initiator-side controller for the data memory (`dm`) in the pipelined MIPS core. It accepts one load/store request at a time from the MEM stage and drives the `dm` word port. It performs sign/zero extension for sub-word loads and read-modify-write for `sb`/`sh`. It flags misaligned and out-of-range accesses without touching memory.

## Interface
- `DM_BASE`, default `32'h0000_0000`, lowest legal byte address.
- `DM_BYTES`, default `4096`, size of `dm` in bytes (1024 words).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `req`  in  1  request strobe; sampled only while `ready`=1.
- `op`  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; the low byte or low half is used for sb/sh.
- `pc`  in  32  PC of the requesting instruction.
- `ready`  out  1  high in IDLE only.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  extended load result; valid while `done`=1 and held until the next load completes.
- `err`  out  1  qualifies `done`: access was rejected.
- `dm_addr`  out  32  word-aligned byte address to `dm` (`addr` input of dm).
- `dm_wdata`  out  32  to dm `dm_in`.
- `dm_we`  out  1  to dm `memwrite`.
- `dm_re`  out  1  to dm `memread`.
- `dm_pc`  out  32  to dm `pc_new`; the latched `pc`.
- `dm_rdata`  in  32  from dm `dm_out`; combinational read of `dm_addr`.

## Operation
- States: IDLE, LD, RD, WR, DONE.
- IDLE, `req`=1:
  - Latch `op`, `addr`, `wdata`, `pc`.
  - Misaligned access goes to DONE with err=1. Misaligned means lw/sw with `addr[1:0]`≠0, or lh/lhu/sh with `addr[0]`≠0.
  - Out-of-range access goes to DONE with err=1. Out of range means `addr` < DM_BASE or `addr` ≥ DM_BASE+DM_BYTES.
  - Otherwise: loads go to LD, sw goes to WR, sb/sh go to RD.
- LD: `dm_re`=1. Select the byte lane with `addr[1:0]` or the half with `addr[1]` (little-endian). Extend the selection: lb/lh sign-extend, lbu/lhu zero-extend; lw passes the word. Register the result into `rdata`. Next state DONE.
- RD: `dm_re`=1. Capture `dm_rdata` into the merge register. Next state WR.
- WR: `dm_we`=1.
  - sw: `dm_wdata` = `wdata`.
  - sb: merge register with `wdata[7:0]` in lane `addr[1:0]`.
  - sh: merge register with `wdata[15:0]` in half `addr[1]`.
  - Next state DONE.
- DONE: `done`=1. `err` is set if the access was rejected. Next state IDLE.
- `dm_addr` = {latched `addr[31:2]`, 2'b00}. `dm_pc` = latched `pc`. Both are stable from LD/RD/WR entry through DONE.
- `dm_we`, `dm_re`, `ready`, `done` and `err` decode from the state register only. There is no combinational path from `req` to them.
- `req` while `ready`=0 is ignored. The requester holds off until `ready`.
- `rdata` is unchanged by stores and by rejected accesses.

## Timing
- Reset (async, low): state goes to IDLE. All registers and all outputs go to 0 except `ready`, which goes to 1. `dm_we` drops immediately.
- An RMW interrupted by reset before WR leaves memory unmodified.
- Request accepted at edge T (IDLE):
  - lw/lh/lhu/lb/lbu: LD in cycle T+1, `done` in T+2.
  - sw: WR in T+1, `done` in T+2.
  - sb/sh: RD in T+1, WR in T+2, `done` in T+3.
  - Error: `done`+`err` in T+1, with no `dm_re`/`dm_we` asserted.
- `ready` returns high in the cycle after DONE. Maximum throughput is one access per 3 cycles (4 for RMW).
- `dm` commits the write on the edge ending the WR cycle. A load issued next therefore observes the new data.

## Test plan
- Reset asserted mid-RMW (during RD, word 0x10 = 0x11223344):
  - `dm_we` is never asserted.
  - After release, lw 0x10 returns 0x11223344.
  - `ready`=1 and all other outputs are 0 during reset.
- sw 0x0 ← 0xDEADBEEF, then lw 0x0:
  - `done` comes 2 cycles after each accept.
  - `rdata`=0xDEADBEEF.
  - `dm_pc` equals the issuing `pc`.
- Word 0x4 = 0x8077F0FF:
  - lb 0x4 → 0xFFFFFFFF; lbu 0x5 → 0x000000F0.
  - lh 0x6 → 0xFFFF8077; lhu 0x6 → 0x00008077.
- Word 0x8 = 0x11223344:
  - sb 0x9 ← 0xAA → word 0x1122AA44.
  - sh 0xA ← 0x5566 → word 0x5566AA44.
  - Each takes 3 cycles, with a single `dm_we` pulse.
- Error cases, each giving `done`=`err`=1 one cycle after accept, no `dm_we`/`dm_re`, memory unchanged:
  - lw 0x2 (misaligned).
  - sh 0x3 (misaligned).
  - sw 0x1000 with DM_BYTES=4096 (out of range).
- Back-to-back: `req` held high continuously.
  - Exactly one access per IDLE visit.
  - Requests asserted during LD/WR/DONE are ignored.
